// File: rtl/video_timing_pkg.sv
// video_timing_pkg: raster segment type and default 640x480@60 timing constants
package video_timing_pkg;
  typedef enum logic [1:0] {SEG_ACTIVE, SEG_FRONT, SEG_SYNC, SEG_BACK} seg_t;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_X_WIDTH  = 10;
  localparam int DEF_Y_WIDTH  = 10;
endpackage

// File: rtl/video_timing_gen_axis.sv
// timing_axis_counter: one raster axis position counter tracking its ACTIVE/FRONT/SYNC/BACK segment
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACT   = DEF_H_ACTIVE,
  parameter int FP    = DEF_H_FRONT,
  parameter int SW    = DEF_H_SYNC,
  parameter int BP    = DEF_H_BACK,
  parameter int WIDTH = DEF_X_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  output logic [WIDTH-1:0] count,
  output seg_t             seg,
  output logic             wrap
);
  localparam int TOTAL = ACT + FP + SW + BP;
  localparam logic [WIDTH-1:0] ACT_END   = WIDTH'(ACT - 1);
  localparam logic [WIDTH-1:0] FRONT_END = WIDTH'(ACT + FP - 1);
  localparam logic [WIDTH-1:0] SYNC_END  = WIDTH'(ACT + FP + SW - 1);
  localparam logic [WIDTH-1:0] LAST      = WIDTH'(TOTAL - 1);
  if (FP == 0 || SW == 0 || BP == 0 || TOTAL > (1 << WIDTH)) begin : g_bad_cfg
    $fatal(1, "timing_axis_counter: zero porch/sync width or WIDTH cannot hold TOTAL-1");
  end
  logic [WIDTH-1:0] count_d, count_q;
  seg_t             seg_d, seg_q;
  logic             seg_end;
  // Advance position on step; move to the next segment when the current one hits its last count
  always_comb begin
    seg_end = (seg_q == SEG_ACTIVE) ? (count_q == ACT_END) :
              (seg_q == SEG_FRONT)  ? (count_q == FRONT_END) :
              (seg_q == SEG_SYNC)   ? (count_q == SYNC_END) : (count_q == LAST);
    count_d = !step ? count_q : (count_q == LAST) ? '0 : count_q + WIDTH'(1);
    seg_d   = (step && seg_end) ? seg_t'(seg_q + 2'd1) : seg_q;
  end
  // Position and segment state
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      seg_q   <= SEG_ACTIVE;
    end else begin
      count_q <= count_d;
      seg_q   <= seg_d;
    end
  end
  assign count = count_q;
  assign seg   = seg_q;
  assign wrap  = (count_q == LAST);
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: registered raster timing (sync/active/x/y/pulses); VIDEO_TIMING_FRAME_COUNT_EN adds frame_count
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int X_WIDTH    = DEF_X_WIDTH,
  parameter int Y_WIDTH    = DEF_Y_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               line_start,
  output logic               frame_start
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0]        frame_count
`endif
);
  logic [X_WIDTH-1:0] h_count, x_d, x_q;
  logic [Y_WIDTH-1:0] v_count, y_d, y_q;
  seg_t               h_seg, v_seg;
  logic               h_wrap, v_wrap;
  logic               hsync_d, hsync_q, vsync_d, vsync_q, active_d, active_q;
  logic               line_start_d, line_start_q, frame_start_d, frame_start_q;
  logic               origin_d, origin_q;
  timing_axis_counter #(.ACT(H_ACTIVE), .FP(H_FRONT), .SW(H_SYNC), .BP(H_BACK), .WIDTH(X_WIDTH)) u_h (
    .clk(clk), .reset(reset), .step(en), .count(h_count), .seg(h_seg), .wrap(h_wrap)
  );
  timing_axis_counter #(.ACT(V_ACTIVE), .FP(V_FRONT), .SW(V_SYNC), .BP(V_BACK), .WIDTH(Y_WIDTH)) u_v (
    .clk(clk), .reset(reset), .step(en && h_wrap), .count(v_count), .seg(v_seg), .wrap(v_wrap)
  );
  // Decode the current position into the next presented outputs; origin_q flags (0,0) without wide compares
  always_comb begin
    x_d           = en ? h_count : x_q;
    y_d           = en ? v_count : y_q;
    hsync_d       = en ? ((h_seg == SEG_SYNC) ? H_SYNC_POL : ~H_SYNC_POL) : hsync_q;
    vsync_d       = en ? ((v_seg == SEG_SYNC) ? V_SYNC_POL : ~V_SYNC_POL) : vsync_q;
    active_d      = en ? (h_seg == SEG_ACTIVE && v_seg == SEG_ACTIVE) : active_q;
    origin_d      = en ? (h_wrap && v_wrap) : origin_q;
    line_start_d  = en && (h_count == '0);
    frame_start_d = en && origin_q;
  end
  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      active_q      <= 1'b0;
      origin_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      origin_q      <= origin_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_count_d, frame_count_q;
  // Count frames on the edge that presents frame_start
  always_comb frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
  // Frame counter register
  always_ff @(posedge clk) frame_count_q <= reset ? 16'd0 : frame_count_d;
  assign frame_count = frame_count_q;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized self-checking bench against a position-arithmetic raster model
module tb_video_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, en = 1'b0;
  logic hsync, vsync, active, line_start, frame_start;
  logic [3:0] x;
  logic [2:0] y;
  logic reset2 = 1'b1, en2 = 1'b0;
  logic hs2, vs2, act2, ls2, fs2;
  logic [9:0] x2, y2;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_count, fc2;
`endif
  int total = 0, bad = 0;
  int n = 0;
  bit pulse = 1'b0;
  logic [15:0] fc = 16'd0;
  typedef struct packed {
    logic hs; logic vs; logic act; logic [3:0] x; logic [2:0] y; logic ls; logic fs;
  } obs_t;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .X_WIDTH(4), .Y_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .hsync(hsync), .vsync(vsync), .active(active),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  video_timing_gen d640 (
    .clk(clk), .reset(reset2), .en(en2), .hsync(hs2), .vsync(vs2), .active(act2),
    .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    , .frame_count(fc2)
`endif
  );

  function automatic obs_t model(input int k, input bit p);
    obs_t o;
    int idx, h, v;
    o = '0;
    if (k == 0) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
      return o;
    end
    idx = (k - 1) % 98;
    h = idx % 14;
    v = idx / 14;
    o.hs  = !(h >= 10 && h < 12);
    o.vs  = !(v == 5);
    o.act = (h < 8) && (v < 4);
    o.x   = 4'(h);
    o.y   = 3'(v);
    o.ls  = p && (h == 0);
    o.fs  = p && (idx == 0);
    return o;
  endfunction

  function automatic obs_t observed();
    return obs_t'({hsync, vsync, active, x, y, line_start, frame_start});
  endfunction

  task automatic tick(input bit r, input bit e);
    @(negedge clk);
    reset = r;
    en = e;
    @(posedge clk);
    #1;
    if (r) begin
      n = 0; pulse = 1'b0; fc = 16'd0;
    end else if (e) begin
      n++; pulse = 1'b1;
      if ((n - 1) % 98 == 0) fc = fc + 16'd1;
    end else pulse = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    total++;
    if (observed() !== model(n, pulse)) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", observed(), model(n, pulse));
    end
  endtask

  task automatic test_first_line();
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b1);
      total++;
      if (observed() !== model(n, pulse)) begin
        bad++;
        $display("FAIL first_line edge=%0d got=%h want=%h", i + 1, observed(), model(n, pulse));
      end
    end
  endtask

  task automatic test_full_frame();
    int fs_seen = 0;
    for (int i = 0; i < 98; i++) begin
      tick(1'b0, 1'b1);
      fs_seen += int'(frame_start);
      total++;
      if (observed() !== model(n, pulse)) begin
        bad++;
        $display("FAIL full_frame n=%0d got=%h want=%h", n, observed(), model(n, pulse));
      end
    end
    total++;
    if (fs_seen != 1) begin
      bad++;
      $display("FAIL frame_start_count got=%0d want=1", fs_seen);
    end
  endtask

  task automatic test_en_toggle();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int guard = 0;
    foreach (pat[i]) begin
      tick(1'b0, pat[i]);
      total++;
      if (observed() !== model(n, pulse)) begin
        bad++;
        $display("FAIL en_pattern step=%0d got=%h want=%h", i, observed(), model(n, pulse));
      end
    end
    while (((n - 1) % 98) % 14 != 13 && guard < 20) begin
      tick(1'b0, 1'b1);
      guard++;
    end
    tick(1'b0, 1'b1);
    total++;
    if (line_start !== 1'b1 || observed() !== model(n, pulse)) begin
      bad++;
      $display("FAIL line_start_on got=%h want=%h", observed(), model(n, pulse));
    end
    tick(1'b0, 1'b0);
    total++;
    if (line_start !== 1'b0 || observed() !== model(n, pulse)) begin
      bad++;
      $display("FAIL line_start_clear got=%h want=%h", observed(), model(n, pulse));
    end
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)));
      total++;
      if (observed() !== model(n, pulse)) begin
        bad++;
        $display("FAIL random_en i=%0d got=%h want=%h", i, observed(), model(n, pulse));
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (!(n > 0 && ((n - 1) % 98) == 2 * 14 + 6) && guard < 200) begin
      tick(1'b0, 1'b1);
      guard++;
    end
    total++;
    if (x !== 4'd6 || y !== 3'd2) begin
      bad++;
      $display("FAIL mid_reset_reach got x=%0d y=%0d want x=6 y=2", x, y);
    end
    tick(1'b1, 1'b1);
    total++;
    if (observed() !== model(n, pulse)) begin
      bad++;
      $display("FAIL mid_reset got=%h want=%h", observed(), model(n, pulse));
    end
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b1);
      total++;
      if (observed() !== model(n, pulse)) begin
        bad++;
        $display("FAIL restart edge=%0d got=%h want=%h", i + 1, observed(), model(n, pulse));
      end
    end
  endtask

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  task automatic test_frame_count();
    int guard = 0;
    tick(1'b1, 1'b1);
    while (fc != 16'd3 && guard < 400) begin
      tick(1'b0, 1'($urandom_range(0, 3) != 0));
      guard++;
      total++;
      if (frame_count !== fc) begin
        bad++;
        $display("FAIL frame_count got=%0d want=%0d", frame_count, fc);
      end
    end
    total++;
    if (frame_count !== 16'd3) begin
      bad++;
      $display("FAIL frame_count_three got=%0d want=3", frame_count);
    end
    @(negedge clk);
    en = 1'b0;
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    pulse = 1'b0;
    fc = 16'hFFFF;
    guard = 0;
    while (fc != 16'd0 && guard < 200) begin
      tick(1'b0, 1'b1);
      guard++;
      total++;
      if (frame_count !== fc) begin
        bad++;
        $display("FAIL frame_count_wrap got=%h want=%h", frame_count, fc);
      end
    end
  endtask
`endif

  task automatic test_default_640();
    logic [4:0] got, want;
    @(negedge clk);
    reset2 = 1'b1;
    @(negedge clk);
    reset2 = 1'b0;
    en2 = 1'b1;
    for (int k = 0; k < 810; k++) begin
      @(posedge clk);
      #1;
      got  = {hs2, vs2, act2, ls2, fs2};
      want = {!(k % 800 >= 656 && k % 800 < 752), 1'b1, (k % 800) < 640, (k % 800) == 0, k == 0};
      total++;
      if (got !== want || x2 !== 10'(k % 800) || y2 !== 10'(k / 800)) begin
        bad++;
        $display("FAIL default_640 k=%0d got=%b x=%0d y=%0d want=%b", k, got, x2, y2, want);
      end
    end
    @(negedge clk);
    en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_full_frame();
    test_en_toggle();
    test_mid_reset();
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    test_frame_count();
`endif
    test_default_640();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
